// File: rtl/sram_controller.sv
// Single-port asynchronous SRAM sequencer: each request runs IDLE -> SETUP -> ACCESS -> HOLD.
// All outputs come straight from flops, so the RAM strobes never glitch.
module sram_controller #(
  parameter int depth       = 16,
  parameter int width       = 8,
  parameter int wait_cycles = 2
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [depth-1:0] i_addr,
  input  logic [width-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_ack,
  output logic [width-1:0] o_rdata,
  output logic [depth-1:0] o_sram_addr,
  output logic             o_sram_enable_x,
  output logic             o_sram_write_x,
  output logic [width-1:0] o_sram_data,
  input  logic [width-1:0] i_sram_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(wait_cycles - 1);

  state_t     state;
  logic       we_q;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      cnt             <= 8'd0;
      o_busy          <= 1'b0;
      o_ack           <= 1'b0;
      o_rdata         <= '0;
      o_sram_addr     <= '0;
      o_sram_data     <= '0;
      o_sram_enable_x <= 1'b1;
      o_sram_write_x  <= 1'b1;
    end else begin
      o_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Address/data/direction are frozen here and only reloaded on the next accept.
          if (i_req) begin
            we_q            <= i_we;
            o_sram_addr     <= i_addr;
            o_sram_data     <= i_wdata;
            o_busy          <= 1'b1;
            o_sram_enable_x <= 1'b0;
            o_sram_write_x  <= 1'b1;
            state           <= SETUP;
          end
        end
        SETUP: begin
          cnt            <= CNT_LOAD;
          o_sram_write_x <= ~we_q;
          state          <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 8'd0) begin
            o_sram_write_x <= 1'b1;
            o_ack          <= 1'b1;
            if (!we_q) o_rdata <= i_sram_data;
            state          <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          o_sram_enable_x <= 1'b1;
          o_busy          <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (wait_cycles 2 and 1), each with a behavioural RAM.
module tb_sram_controller;

  logic             clk = 1'b0;
  logic             rst_x;
  logic [1:0]       req, we, busy, ack, en_x, wr_x;
  logic [1:0][15:0] addr, saddr;
  logic [1:0][7:0]  wdata, rdata, sdout, sdin;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem0 [0:65535] = '{default: 8'h00};
  logic [7:0] mem1 [0:65535] = '{default: 8'h00};

  always #10 clk = ~clk;

  sram_controller #(.depth(16), .width(8), .wait_cycles(2)) dut0 (
    .clk(clk), .rst_x(rst_x), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .o_busy(busy[0]), .o_ack(ack[0]), .o_rdata(rdata[0]),
    .o_sram_addr(saddr[0]), .o_sram_enable_x(en_x[0]), .o_sram_write_x(wr_x[0]),
    .o_sram_data(sdout[0]), .i_sram_data(sdin[0]));

  sram_controller #(.depth(16), .width(8), .wait_cycles(1)) dut1 (
    .clk(clk), .rst_x(rst_x), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .o_busy(busy[1]), .o_ack(ack[1]), .o_rdata(rdata[1]),
    .o_sram_addr(saddr[1]), .o_sram_enable_x(en_x[1]), .o_sram_write_x(wr_x[1]),
    .o_sram_data(sdout[1]), .i_sram_data(sdin[1]));

  // RAM models: write while both strobes are low, read combinationally when enabled.
  always @(posedge clk) begin
    if (!en_x[0] && !wr_x[0]) mem0[saddr[0]] <= sdout[0];
    if (!en_x[1] && !wr_x[1]) mem1[saddr[1]] <= sdout[1];
  end
  assign sdin[0] = (!en_x[0] && wr_x[0]) ? mem0[saddr[0]] : 8'h00;
  assign sdin[1] = (!en_x[1] && wr_x[1]) ? mem1[saddr[1]] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance sel; inputs are scrambled right after accept.
  task automatic txn(input int sel, input bit w, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] prior, input logic [7:0] newr);
    int wc;
    wc = (sel == 0) ? 2 : 1;
    @(negedge clk);
    req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d;
    @(posedge clk);
    @(negedge clk);
    req[sel] = 1'b0; we[sel] = ~w; addr[sel] = 16'hFFFF; wdata[sel] = 8'h00;
    for (int k = 0; k <= wc + 2; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("busy%0d_k%0d", sel, k), busy[sel], (k <= wc + 1));
      chk($sformatf("en_x%0d_k%0d", sel, k), en_x[sel], !(k <= wc + 1));
      chk($sformatf("wr_x%0d_k%0d", sel, k), wr_x[sel], !(w && k >= 1 && k <= wc));
      chk($sformatf("ack%0d_k%0d", sel, k), ack[sel], (k == wc + 1));
      chk($sformatf("rdata%0d_k%0d", sel, k), rdata[sel],
          (!w && k >= wc + 1) ? newr : prior);
      if (k <= wc + 1) begin
        chk($sformatf("saddr%0d_k%0d", sel, k), saddr[sel], a);
        chk($sformatf("sdata%0d_k%0d", sel, k), sdout[sel], d);
      end
    end
  endtask

  initial begin
    int acks;
    rst_x = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    #15;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_busy%0d", s), busy[s], 1'b0);
      chk($sformatf("rst_ack%0d", s), ack[s], 1'b0);
      chk($sformatf("rst_en%0d", s), en_x[s], 1'b1);
      chk($sformatf("rst_wr%0d", s), wr_x[s], 1'b1);
      chk($sformatf("rst_addr%0d", s), saddr[s], 16'h0);
      chk($sformatf("rst_data%0d", s), sdout[s], 8'h0);
      chk($sformatf("rst_rdata%0d", s), rdata[s], 8'h0);
    end
    @(negedge clk); rst_x = 1'b1;

    // Write then read back through the 2-wait instance.
    txn(0, 1'b1, 16'h1234, 8'hA5, 8'h00, 8'h00);
    chk("mem_1234", mem0[16'h1234], 8'hA5);
    txn(0, 1'b0, 16'h1234, 8'h00, 8'h00, 8'hA5);

    // Three back-to-back reads with i_req held.
    txn(0, 1'b1, 16'h0001, 8'h3C, 8'hA5, 8'hA5);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0001; wdata[0] = 8'h00;
    @(posedge clk);
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy_k%0d", k), busy[0], (k % 5 != 4));
      if (ack[0]) acks++;
      if (k == 14) req[0] = 1'b0;
    end
    chk("b2b_acks", acks, 3);
    chk("b2b_rdata", rdata[0], 8'h3C);
    @(negedge clk);
    chk("b2b_idle", busy[0], 1'b0);

    // Inputs change during SETUP; RAM must only see the latched request.
    txn(0, 1'b1, 16'h0010, 8'h77, 8'h3C, 8'h3C);
    chk("mem_0010", mem0[16'h0010], 8'h77);
    chk("mem_ffff_untouched", mem0[16'hFFFF], 8'h00);

    // o_rdata holds through a write and updates on the read only.
    txn(0, 1'b1, 16'h0002, 8'h11, 8'h3C, 8'h3C);
    txn(0, 1'b0, 16'h0002, 8'h00, 8'h3C, 8'h11);

    // Reset in the middle of ACCESS of a write.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 8'h99;
    @(posedge clk);
    @(negedge clk); req[0] = 1'b0;
    @(posedge clk); #5;
    chk("mid_wr_low", wr_x[0], 1'b0);
    rst_x = 1'b0; #1;
    chk("arst_en", en_x[0], 1'b1);
    chk("arst_wr", wr_x[0], 1'b1);
    chk("arst_busy", busy[0], 1'b0);
    chk("arst_addr", saddr[0], 16'h0);
    chk("arst_data", sdout[0], 8'h0);
    chk("arst_rdata", rdata[0], 8'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("arst_ack_k%0d", k), ack[0], 1'b0);
    end
    rst_x = 1'b1;

    // wait_cycles=1 instance.
    txn(1, 1'b1, 16'hFFFF, 8'h5A, 8'h00, 8'h00);
    chk("mem1_ffff", mem1[16'hFFFF], 8'h5A);
    txn(1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
